// File: rtl/accumulator_control.sv
// Multicycle control FSM for the accumulator datapath: fetches over a handshaked
// memory port, decodes the 4-bit opcode and sequences the selects/enables per instruction.
module accumulator_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] iord,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op,
  output logic [2:0] AccSrc,
  output logic       AccWrite,
  output logic       SpWrite,
  output logic       halted,
  output logic       illegal,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    FETCH, DECODE, ACC_IMM, ALU_EXE, MEM_RD, WB_MDR, SP_DEC, MEM_WR, BRANCH, HALT
  } state_t;

  localparam logic [3:0] OP_LUI   = 4'h0;
  localparam logic [3:0] OP_LI    = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_PUSH  = 4'h5;
  localparam logic [3:0] OP_POP   = 4'h6;
  localparam logic [3:0] OP_BEQZ  = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        stateReg, stateNext;
  logic [3:0]    opReg;
  logic [CW-1:0] waitReg;
  logic          haltedReg, illegalReg, memErrReg;
  logic          memState, timeout, illegalOp;

  assign memState = (stateReg == FETCH) || (stateReg == MEM_RD) || (stateReg == MEM_WR);
  // The edge that would complete the MEM_TIMEOUT-th idle cycle diverts to HALT instead.
  assign timeout  = (MEM_TIMEOUT != 0) && memState && !mem_ready &&
                    (waitReg == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    illegalOp = 1'b1;
    case (opcode)
      OP_LUI, OP_LI, OP_ADDI, OP_LOAD, OP_STORE, OP_PUSH,
      OP_POP, OP_BEQZ, OP_JMP, OP_HALT: illegalOp = 1'b0;
      default:                          illegalOp = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      stateReg   <= FETCH;
      opReg      <= '0;
      waitReg    <= '0;
      haltedReg  <= 1'b0;
      illegalReg <= 1'b0;
      memErrReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == DECODE) opReg <= opcode;
      if (stateNext != stateReg)       waitReg <= '0;
      else if (memState && !mem_ready) waitReg <= waitReg + CW'(1);
      if (stateNext == HALT)                 haltedReg  <= 1'b1;
      if (stateReg == DECODE && illegalOp)   illegalReg <= 1'b1;
      if (timeout)                           memErrReg  <= 1'b1;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      FETCH:  if (timeout) stateNext = HALT; else if (mem_ready) stateNext = DECODE;
      DECODE: begin
        case (opcode)
          OP_LUI, OP_LI:   stateNext = ACC_IMM;
          OP_ADDI:         stateNext = ALU_EXE;
          OP_LOAD, OP_POP: stateNext = MEM_RD;
          OP_STORE:        stateNext = MEM_WR;
          OP_PUSH:         stateNext = SP_DEC;
          OP_BEQZ, OP_JMP: stateNext = BRANCH;
          default:         stateNext = HALT;
        endcase
      end
      ACC_IMM, ALU_EXE, WB_MDR, BRANCH: stateNext = FETCH;
      MEM_RD: if (timeout) stateNext = HALT; else if (mem_ready) stateNext = WB_MDR;
      SP_DEC: stateNext = MEM_WR;
      MEM_WR: if (timeout) stateNext = HALT; else if (mem_ready) stateNext = FETCH;
      HALT:   stateNext = HALT;
      default: stateNext = FETCH;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = 1'b0;
    AccSrc    = 3'b000;
    AccWrite  = 1'b0;
    SpWrite   = 1'b0;
    case (stateReg)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ACC_IMM: begin
        AccWrite = 1'b1;
        AccSrc   = (opReg == OP_LI) ? 3'b011 : 3'b000;
      end
      ALU_EXE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        AccSrc    = 3'b100;
        AccWrite  = 1'b1;
      end
      MEM_RD: begin
        mem_read  = 1'b1;
        iord      = (opReg == OP_POP) ? 2'b10 : 2'b01;
        mdr_write = mem_ready;
      end
      WB_MDR: begin
        AccSrc   = 3'b001;
        AccWrite = 1'b1;
        if (opReg == OP_POP) begin
          SpWrite   = 1'b1;
          alu_src_a = 2'b10;
        end
      end
      SP_DEC: begin
        SpWrite   = 1'b1;
        alu_src_a = 2'b10;
        alu_op    = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = (opReg == OP_PUSH) ? 2'b10 : 2'b01;
      end
      BRANCH: begin
        alu_src_b = 2'b10;
        pc_write  = (opReg == OP_JMP) || ((opReg == OP_BEQZ) && acc_zero);
      end
      default: ;
    endcase
  end

  assign halted  = haltedReg;
  assign illegal = illegalReg;
  assign mem_err = memErrReg;

endmodule
